// File: rtl/jk_ff_monitor_if.sv
// Observation bundle between a JK flip-flop under test and jk_ff_monitor: control, J/K/Q sampling, results.
// The master side drives the observed signals; the slave side is the monitor.
interface jk_ff_monitor_if #(
  parameter int unsigned CHK_CNT_W = 16,
  parameter int unsigned ERR_CNT_W = 8
);
  logic                 Enable_In;
  logic                 Clear_In;
  logic                 DUT_Reset_In;
  logic                 J_In;
  logic                 K_In;
  logic                 Q_In;
  logic                 Qb_In;

  logic                 Expected_Q_Out;
  logic [CHK_CNT_W-1:0] Check_Count_Out;
  logic [ERR_CNT_W-1:0] Error_Count_Out;
  logic                 Error_Flag_Out;
  logic [CHK_CNT_W-1:0] Error_Cycle_Out;
  logic [1:0]           State_Out;
  logic                 Stim_J_Out;
  logic                 Stim_K_Out;

  modport master (
    output Enable_In, Clear_In, DUT_Reset_In, J_In, K_In, Q_In, Qb_In,
    input  Expected_Q_Out, Check_Count_Out, Error_Count_Out, Error_Flag_Out,
           Error_Cycle_Out, State_Out, Stim_J_Out, Stim_K_Out
  );

  modport slave (
    input  Enable_In, Clear_In, DUT_Reset_In, J_In, K_In, Q_In, Qb_In,
    output Expected_Q_Out, Check_Count_Out, Error_Count_Out, Error_Flag_Out,
           Error_Cycle_Out, State_Out, Stim_J_Out, Stim_K_Out
  );
endinterface

// File: rtl/jk_ff_monitor.sv
// Reference-model checker for a JK flip-flop: predicts Q each edge, counts checks and failures.
// Optional J/K stimulus LFSR is built only when JK_STIM_GEN_EN is defined.
module jk_ff_monitor #(
  parameter int unsigned CHK_CNT_W   = 16,
  parameter int unsigned ERR_CNT_W   = 8,
  parameter bit          HALT_ON_ERR = 1'b0
) (
  input  logic           Clk_In,
  input  logic           Reset_In,
  jk_ff_monitor_if.slave mon
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_CHECK = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [CHK_CNT_W-1:0] CHK_MAX = '1;
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  state_t               state_q, state_d;
  logic                 exp_q_q, exp_q_d;
  logic [CHK_CNT_W-1:0] chk_cnt_q, chk_cnt_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 err_flag_q, err_flag_d;
  logic [CHK_CNT_W-1:0] err_cycle_q, err_cycle_d;

  logic predicted_q;
  logic check_fail;
  logic do_check;

  // Next Q the flip-flop should present, from the samples at this edge.
  always_comb begin
    predicted_q = mon.Q_In;
    unique case ({mon.J_In, mon.K_In})
      2'b00: predicted_q = mon.Q_In;
      2'b01: predicted_q = 1'b0;
      2'b10: predicted_q = 1'b1;
      2'b11: predicted_q = ~mon.Q_In;
    endcase
    if (mon.DUT_Reset_In) predicted_q = 1'b0;
  end

  assign check_fail = (mon.Q_In != exp_q_q) || (mon.Qb_In == mon.Q_In);
  assign do_check   = (state_q == ST_CHECK) && mon.Enable_In;

  always_comb begin
    // NOTE: every _d starts from its _q so no path leaves a variable unassigned (no latches).
    state_d     = state_q;
    exp_q_d     = exp_q_q;
    chk_cnt_d   = chk_cnt_q;
    err_cnt_d   = err_cnt_q;
    err_flag_d  = err_flag_q;
    err_cycle_d = err_cycle_q;

    if (!mon.Enable_In) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_SYNC;
        ST_SYNC: begin
          exp_q_d = predicted_q;
          state_d = ST_CHECK;
        end
        ST_CHECK: begin
          exp_q_d = predicted_q;
          if (check_fail && HALT_ON_ERR) state_d = ST_HALT;
        end
        ST_HALT: state_d = ST_HALT;
      endcase
    end

    if (do_check) begin
      if (chk_cnt_q != CHK_MAX) chk_cnt_d = chk_cnt_q + CHK_CNT_W'(1);
      if (check_fail) begin
        if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        if (!err_flag_q) begin
          err_flag_d  = 1'b1;
          err_cycle_d = chk_cnt_q;
        end
      end
    end

    // Clear beats a coincident check; it also releases HALT back into checking.
    if (mon.Clear_In) begin
      chk_cnt_d   = '0;
      err_cnt_d   = '0;
      err_flag_d  = 1'b0;
      err_cycle_d = '0;
      if (mon.Enable_In && (state_q == ST_HALT || state_q == ST_CHECK)) begin
        state_d = ST_CHECK;
        exp_q_d = predicted_q;
      end
    end
  end

  always_ff @(posedge Clk_In or negedge Reset_In) begin
    if (!Reset_In) begin
      state_q     <= ST_IDLE;
      exp_q_q     <= 1'b0;
      chk_cnt_q   <= '0;
      err_cnt_q   <= '0;
      err_flag_q  <= 1'b0;
      err_cycle_q <= '0;
    end else begin
      // NOTE: non-blocking so every register sees the pre-edge values of the others.
      state_q     <= state_d;
      exp_q_q     <= exp_q_d;
      chk_cnt_q   <= chk_cnt_d;
      err_cnt_q   <= err_cnt_d;
      err_flag_q  <= err_flag_d;
      err_cycle_q <= err_cycle_d;
    end
  end

`ifdef JK_STIM_GEN_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  logic [15:0] lfsr_q, lfsr_d;
  logic        stim_j_q, stim_j_d;
  logic        stim_k_q, stim_k_d;

  // Fibonacci LFSR, taps 16,14,13,11; restarts from the seed on every entry to SYNC.
  always_comb begin
    lfsr_d   = lfsr_q;
    stim_j_d = stim_j_q;
    stim_k_d = stim_k_q;
    if (state_d == ST_SYNC && state_q != ST_SYNC) begin
      lfsr_d = LFSR_SEED;
    end else if (state_q == ST_SYNC || state_q == ST_CHECK) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
    if (lfsr_d != lfsr_q) begin
      stim_j_d = lfsr_d[0];
      stim_k_d = lfsr_d[1];
    end
  end

  always_ff @(posedge Clk_In or negedge Reset_In) begin
    if (!Reset_In) begin
      lfsr_q   <= LFSR_SEED;
      stim_j_q <= 1'b0;
      stim_k_q <= 1'b0;
    end else begin
      lfsr_q   <= lfsr_d;
      stim_j_q <= stim_j_d;
      stim_k_q <= stim_k_d;
    end
  end

  assign mon.Stim_J_Out = stim_j_q;
  assign mon.Stim_K_Out = stim_k_q;
`else
  assign mon.Stim_J_Out = 1'b0;
  assign mon.Stim_K_Out = 1'b0;
`endif

  assign mon.Expected_Q_Out  = exp_q_q;
  assign mon.Check_Count_Out = chk_cnt_q;
  assign mon.Error_Count_Out = err_cnt_q;
  assign mon.Error_Flag_Out  = err_flag_q;
  assign mon.Error_Cycle_Out = err_cycle_q;
  assign mon.State_Out       = state_q;

endmodule

// File: tb/tb_jk_ff_monitor.sv
// Bench for jk_ff_monitor: two instances (HALT_ON_ERR 0 and 1) beside an ideal JK flip-flop,
// random and directed stimulus checked against a behavioural model.
module tb_jk_ff_monitor;
  localparam int CW = 16;
  localparam int EW = 8;
  localparam int CHK_MAX = 65535;
  localparam int ERR_MAX = 255;
  localparam int S_IDLE = 0, S_SYNC = 1, S_CHECK = 2, S_HALT = 3;

  typedef struct {
    int st;
    bit exp_q;
    int chk;
    int err;
    bit flag;
    int cyc;
  } mdl_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic en = 0, clr = 0, drst = 0, tj = 0, tk = 0;
  logic use_stim = 0, force_q = 0, force_val = 0, tie_qb = 0;
  logic q_ff = 0;
  logic j_app, k_app, q_app, qb_app;

  int n_total = 0;
  int n_bad = 0;
  mdl_t m0, m1;

  jk_ff_monitor_if #(.CHK_CNT_W(CW), .ERR_CNT_W(EW)) if0 ();
  jk_ff_monitor_if #(.CHK_CNT_W(CW), .ERR_CNT_W(EW)) if1 ();

  jk_ff_monitor #(.CHK_CNT_W(CW), .ERR_CNT_W(EW), .HALT_ON_ERR(1'b0)) dut0 (
    .Clk_In(clk), .Reset_In(rst_n), .mon(if0));
  jk_ff_monitor #(.CHK_CNT_W(CW), .ERR_CNT_W(EW), .HALT_ON_ERR(1'b1)) dut1 (
    .Clk_In(clk), .Reset_In(rst_n), .mon(if1));

  assign j_app  = use_stim ? if0.Stim_J_Out : tj;
  assign k_app  = use_stim ? if0.Stim_K_Out : tk;
  assign q_app  = force_q ? force_val : q_ff;
  assign qb_app = tie_qb ? q_app : ~q_app;

  assign if0.Enable_In = en;   assign if1.Enable_In = en;
  assign if0.Clear_In = clr;   assign if1.Clear_In = clr;
  assign if0.DUT_Reset_In = drst; assign if1.DUT_Reset_In = drst;
  assign if0.J_In = j_app;     assign if1.J_In = j_app;
  assign if0.K_In = k_app;     assign if1.K_In = k_app;
  assign if0.Q_In = q_app;     assign if1.Q_In = q_app;
  assign if0.Qb_In = qb_app;   assign if1.Qb_In = qb_app;

  // Ideal flip-flop under test.
  always @(posedge clk) begin
    if (drst) q_ff <= 1'b0;
    else if (j_app && k_app) q_ff <= ~q_ff;
    else if (j_app) q_ff <= 1'b1;
    else if (k_app) q_ff <= 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic mdl_t model_reset();
    mdl_t r;
    r.st = S_IDLE; r.exp_q = 0; r.chk = 0; r.err = 0; r.flag = 0; r.cyc = 0;
    return r;
  endfunction

  function automatic mdl_t step(mdl_t m, bit halt, bit e, bit c, bit r, bit j, bit k, bit q, bit qb);
    mdl_t n = m;
    bit nxt, bad;
    if (r) nxt = 0;
    else if (j && k) nxt = !q;
    else if (j) nxt = 1;
    else if (k) nxt = 0;
    else nxt = q;
    bad = (q != m.exp_q) || (qb != !q);
    if (!e) n.st = S_IDLE;
    else if (m.st == S_IDLE) n.st = S_SYNC;
    else if (m.st == S_SYNC) begin
      n.st = S_CHECK; n.exp_q = nxt;
    end else if (m.st == S_CHECK) begin
      n.chk = (m.chk + 1 > CHK_MAX) ? CHK_MAX : m.chk + 1;
      if (bad) begin
        n.err = (m.err + 1 > ERR_MAX) ? ERR_MAX : m.err + 1;
        if (!m.flag) begin n.flag = 1; n.cyc = m.chk; end
        if (halt) n.st = S_HALT;
      end
      n.exp_q = nxt;
    end
    if (c) begin
      n.chk = 0; n.err = 0; n.flag = 0; n.cyc = 0;
      if (e && (m.st == S_HALT || m.st == S_CHECK)) begin
        n.st = S_CHECK; n.exp_q = nxt;
      end
    end
    return n;
  endfunction

  task automatic cmp_dut(input string p, input mdl_t m, input logic [1:0] st, input logic eq,
                         input logic [CW-1:0] chk, input logic [EW-1:0] err, input logic fl,
                         input logic [CW-1:0] cyc, input logic sj, input logic sk);
    check({p, "_state"}, st, m.st);
    check({p, "_expq"}, eq, m.exp_q);
    check({p, "_chk"}, chk, m.chk);
    check({p, "_err"}, err, m.err);
    check({p, "_flag"}, fl, m.flag);
    check({p, "_cyc"}, cyc, m.cyc);
`ifndef JK_STIM_GEN_EN
    check({p, "_stimj"}, sj, 0);
    check({p, "_stimk"}, sk, 0);
`endif
  endtask

  task automatic compare_all();
    cmp_dut("d0", m0, if0.State_Out, if0.Expected_Q_Out, if0.Check_Count_Out, if0.Error_Count_Out,
            if0.Error_Flag_Out, if0.Error_Cycle_Out, if0.Stim_J_Out, if0.Stim_K_Out);
    cmp_dut("d1", m1, if1.State_Out, if1.Expected_Q_Out, if1.Check_Count_Out, if1.Error_Count_Out,
            if1.Error_Flag_Out, if1.Error_Cycle_Out, if1.Stim_J_Out, if1.Stim_K_Out);
  endtask

  // Called at a negedge with inputs already set: sample, clock, update model, compare.
  task automatic tick();
    bit se, sc, sr, sj, sk, sq, sqb;
    #1;
    se = en; sc = clr; sr = drst; sj = j_app; sk = k_app; sq = q_app; sqb = qb_app;
    @(posedge clk);
    m0 = step(m0, 1'b0, se, sc, sr, sj, sk, sq, sqb);
    m1 = step(m1, 1'b1, se, sc, sr, sj, sk, sq, sqb);
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_jk(input logic [1:0] jk);
    tj = jk[1]; tk = jk[0];
  endtask

  initial begin
    logic [1:0] seq2 [7];
    seq2 = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b11, 2'b11, 2'b00};
    m0 = model_reset();
    m1 = model_reset();

    #2;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Ideal JK sequence: expect 5 clean checks.
    en = 1;
    for (int i = 0; i < 7; i++) begin
      set_jk(seq2[i]);
      tick();
    end
    check("t2_chk", if0.Check_Count_Out, 5);
    check("t2_err", if0.Error_Count_Out, 0);
    check("t2_flag", if0.Error_Flag_Out, 0);
    check("t2_chk_h", if1.Check_Count_Out, 5);

    // Wrong Q on the third check.
    en = 0; drst = 1; set_jk(2'b00); tick();
    clr = 1; drst = 0; tick();
    clr = 0; en = 1; tick();
    tick();
    tick();
    set_jk(2'b10); tick();
    set_jk(2'b00); force_q = 1; force_val = 0; tick();
    force_q = 0;
    check("t3_flag", if0.Error_Flag_Out, 1);
    check("t3_err", if0.Error_Count_Out, 1);
    check("t3_cyc", if0.Error_Cycle_Out, 2);
    check("t3_halt_state", if1.State_Out, 3);
    check("t3_halt_chk", if1.Check_Count_Out, 3);
    tick();
    tick();
    check("t3_halt_frozen", if1.Check_Count_Out, 3);

    // Qb tied to Q for 300 checks.
    en = 0; tick();
    clr = 1; tick();
    clr = 0; tie_qb = 1; en = 1;
    for (int i = 0; i < 302; i++) begin
      set_jk(2'($urandom_range(0, 3)));
      tick();
    end
    check("t4_err_sat", if0.Error_Count_Out, 255);
    check("t4_chk", if0.Check_Count_Out, 300);
    check("t4_halt_chk", if1.Check_Count_Out, 1);

    // Clear coincident with a failing check, then drop enable mid-run.
    clr = 1; tick();
    check("t5_err", if0.Error_Count_Out, 0);
    check("t5_flag", if0.Error_Flag_Out, 0);
    check("t5_chk", if0.Check_Count_Out, 0);
    check("t5_halt_rel", if1.State_Out, 2);
    clr = 0; tie_qb = 0;
    for (int i = 0; i < 6; i++) begin
      set_jk(2'($urandom_range(0, 3)));
      tick();
    end
    en = 0; tie_qb = 1;
    for (int i = 0; i < 4; i++) begin
      set_jk(2'($urandom_range(0, 3)));
      tick();
    end
    check("t5_idle", if0.State_Out, 0);
    check("t5_hold", if0.Check_Count_Out, 6);
    tie_qb = 0;

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      en        = ($urandom_range(0, 19) != 0);
      clr       = ($urandom_range(0, 39) == 0);
      drst      = ($urandom_range(0, 9) == 0);
      force_q   = ($urandom_range(0, 29) == 0);
      force_val = 1'($urandom_range(0, 1));
      tie_qb    = ($urandom_range(0, 49) == 0);
      set_jk(2'($urandom_range(0, 3)));
      tick();
    end
    en = 1; clr = 0; drst = 0; force_q = 0; tie_qb = 0;
    for (int i = 0; i < 5; i++) tick();

    // Asynchronous reset between edges with counts live.
    #2;
    rst_n = 0;
    m0 = model_reset();
    m1 = model_reset();
    #1;
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    en = 0;
    rst_n = 1;

    // Stimulus loopback into the ideal flip-flop.
    use_stim = 1; en = 1;
    tick();
`ifdef JK_STIM_GEN_EN
    check("t6_stim_j", if0.Stim_J_Out, 1);
    check("t6_stim_k", if0.Stim_K_Out, 0);
`endif
    for (int i = 0; i < 1000; i++) tick();
    check("t6_err", if0.Error_Count_Out, 0);
    check("t6_flag", if0.Error_Flag_Out, 0);
    check("t6_chk", if0.Check_Count_Out, 999);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
